// File: rtl/cache_dm_if.sv
// cache_dm_if: core-side and memory-side signals of the direct-mapped cache
interface cache_dm_if;
    logic        i_req;
    logic        i_wen;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_flush;
    logic        o_ready;
    logic [31:0] o_rdata;
    logic        o_hit;
    logic        o_mreq;
    logic        o_mwen;
    logic [31:0] o_maddr;
    logic [31:0] o_mwdata;
    logic        i_mack;
    logic [31:0] i_mrdata;
    modport master (
        output i_req, i_wen, i_addr, i_wdata, i_flush, i_mack, i_mrdata,
        input  o_ready, o_rdata, o_hit, o_mreq, o_mwen, o_maddr, o_mwdata
    );
    modport slave (
        input  i_req, i_wen, i_addr, i_wdata, i_flush, i_mack, i_mrdata,
        output o_ready, o_rdata, o_hit, o_mreq, o_mwen, o_maddr, o_mwdata
    );
endinterface

// File: rtl/cache_dm.sv
// cache_dm: direct-mapped write-through no-write-allocate cache with multi-word line refill
module cache_dm #(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input logic       clk,
    input logic       rst,
    cache_dm_if.slave bus
);
    localparam int IDX  = $clog2(LINES);
    localparam int OFF  = $clog2(WORDS);
    localparam int OFFW = OFF > 0 ? OFF : 1;
    localparam int TAGW = 30 - IDX - OFF;
    localparam logic [OFFW-1:0] OMASK = OFFW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t            state_q;
    logic [OFFW-1:0]   cnt_q, cnt_d;
    logic [29:0]       base_q;
    logic [31:0]       wdata_q;
    logic [LINES-1:0]  valid_q;
    logic [TAGW-1:0]   tag_q [LINES];
    logic [31:0]       data_q [LINES][WORDS];
    logic              mreq_q, mwen_q;
    logic [31:0]       maddr_q, mwdata_q;
    logic [29:0]       wa, line_base;
    logic [IDX-1:0]    idx, bidx;
    logic [TAGW-1:0]   tag, btag;
    logic [OFFW-1:0]   off, boff;
    logic              hit, bhit;
    logic              unused_addr;

    assign unused_addr = ^bus.i_addr[1:0];
    assign wa        = bus.i_addr[31:2];
    assign idx       = IDX'(wa >> OFF);
    assign tag       = TAGW'(wa >> (OFF + IDX));
    assign off       = OFFW'(wa) & OMASK;
    assign bidx      = IDX'(base_q >> OFF);
    assign btag      = TAGW'(base_q >> (OFF + IDX));
    assign boff      = OFFW'(base_q) & OMASK;
    assign line_base = base_q & ~30'(WORDS - 1);

    // Lookup for the live request, lookup for the latched request, completion and beat counter
    always_comb begin
        hit         = valid_q[idx] && tag_q[idx] == tag;
        bhit        = valid_q[bidx] && tag_q[bidx] == btag;
        cnt_d       = cnt_q == OMASK ? '0 : cnt_q + 1'b1;
        bus.o_hit   = hit;
        bus.o_rdata = data_q[idx][off];
        bus.o_ready = (state_q == IDLE && bus.i_req && !bus.i_wen && !bus.i_flush && hit) ||
                      (state_q == WRITE && bus.i_mack && bus.i_req);
    end

    assign bus.o_mreq   = mreq_q;
    assign bus.o_mwen   = mwen_q;
    assign bus.o_maddr  = maddr_q;
    assign bus.o_mwdata = mwdata_q;

    // Controller: accepts misses and stores, runs refill beats and the write-through beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            mreq_q   <= 1'b0;
            mwen_q   <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_flush) begin
                        valid_q <= '0;
                    end else if (bus.i_req && bus.i_wen) begin
                        state_q  <= WRITE;
                        base_q   <= wa;
                        wdata_q  <= bus.i_wdata;
                        mreq_q   <= 1'b1;
                        mwen_q   <= 1'b1;
                        maddr_q  <= {wa, 2'b00};
                        mwdata_q <= bus.i_wdata;
                    end else if (bus.i_req && !hit) begin
                        state_q      <= REFILL;
                        base_q       <= wa;
                        cnt_q        <= '0;
                        valid_q[idx] <= 1'b0;
                        mreq_q       <= 1'b1;
                        mwen_q       <= 1'b0;
                        maddr_q      <= {wa & ~30'(WORDS - 1), 2'b00};
                    end
                end
                REFILL: begin
                    if (bus.i_mack) begin
                        cnt_q   <= cnt_d;
                        maddr_q <= {line_base | 30'(cnt_d), 2'b00};
                        if (cnt_q == OMASK) begin
                            tag_q[bidx]   <= btag;
                            valid_q[bidx] <= 1'b1;
                            mreq_q        <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.i_mack) begin
                        mreq_q  <= 1'b0;
                        mwen_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data array: refill beats fill the line, write-through hits update the resident word
    always_ff @(posedge clk) begin
        if (!rst && state_q == REFILL && bus.i_mack)
            data_q[bidx][cnt_q] <= bus.i_mrdata;
        else if (!rst && state_q == WRITE && bus.i_mack && bhit)
            data_q[bidx][boff] <= wdata_q;
    end
endmodule

// File: tb/tb_cache_dm.sv
// tb_cache_dm: scoreboard bench for cache_dm with a stalling memory responder
module tb_cache_dm;
    localparam int WORDS = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   stall = 0;
    int   scnt = 0;
    int   last_ack = 0;
    logic [31:0] held;
    logic [31:0] phys [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] ackq [$];
    logic        wq [$];
    logic [31:0] dq [$];
    logic [31:0] exp_q [$];
    logic        res_valid [32];
    logic [22:0] res_tag [32];

    cache_dm_if bus();

    cache_dm #(.LINES(32), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seed(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A5_0F0F;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : seed(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : seed(a);
    endfunction

    // Memory responder: acks each beat after `stall` wait cycles, checks the address holds while waiting
    always @(negedge clk) begin
        if (bus.o_mreq && !rst) begin
            if (scnt > 0) chk("maddr_stable", bus.o_maddr, held);
            if (scnt == stall) begin
                bus.i_mack   = 1'b1;
                bus.i_mrdata = phys_rd(bus.o_maddr);
                ackq.push_back(bus.o_maddr);
                wq.push_back(bus.o_mwen);
                dq.push_back(bus.o_mwdata);
                last_ack = cyc;
                if (bus.o_mwen) phys[bus.o_maddr] = bus.o_mwdata;
                scnt = 0;
            end else begin
                if (scnt == 0) held = bus.o_maddr;
                bus.i_mack = 1'b0;
                scnt++;
            end
        end else begin
            bus.i_mack = 1'b0;
            scnt = 0;
        end
    end

    task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] wa;
        int li, n;
        logic exp_hit;
        wa = {addr[31:2], 2'b00};
        li = int'(addr[8:4]);
        exp_hit = res_valid[li] && res_tag[li] == addr[31:9];
        if (!wen) exp_q.push_back(ref_rd(wa));
        ackq.delete(); wq.delete(); dq.delete();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wen = wen; bus.i_addr = addr; bus.i_wdata = wd;
        #1;
        chk("hit", {31'b0, bus.o_hit}, {31'b0, exp_hit});
        n = 0;
        while (!bus.o_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.o_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else if (!wen) begin
            chk("rdata", bus.o_rdata, exp_q.pop_front());
            if (!exp_hit) chk("miss_lat", cyc - last_ack, 32'd1);
        end else begin
            chk("st_ack", {31'b0, bus.i_mack}, 32'd1);
        end
        bus.i_req = 1'b0;
        chk("beats", ackq.size(), wen ? 1 : (exp_hit ? 0 : WORDS));
        if (wen && ackq.size() == 1) begin
            chk("st_addr", ackq[0], wa);
            chk("st_mwen", {31'b0, wq[0]}, 32'd1);
            chk("st_data", dq[0], wd);
            refm[wa] = wd;
        end else if (!wen && !exp_hit) begin
            for (int k = 0; k < ackq.size(); k++) begin
                chk("rf_addr", ackq[k], {addr[31:4], 4'(k * 4)});
                chk("rf_mwen", {31'b0, wq[k]}, 32'd0);
            end
            res_valid[li] = 1'b1;
            res_tag[li] = addr[31:9];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) res_valid[i] = 1'b0;
    endtask

    initial begin
        int n;
        bus.i_req = 1'b0; bus.i_wen = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.i_flush = 1'b0; bus.i_mack = 1'b0; bus.i_mrdata = '0;
        clear_model();
        for (int i = 0; i < 32; i++) res_tag[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        chk("rst_mreq", {31'b0, bus.o_mreq}, 32'd0);
        chk("rst_mwen", {31'b0, bus.o_mwen}, 32'd0);
        chk("rst_maddr", bus.o_maddr, 32'd0);
        chk("rst_mwdata", bus.o_mwdata, 32'd0);

        access(1'b0, 32'h0000_1004, '0);
        access(1'b0, 32'h0000_100C, '0);
        access(1'b0, 32'h0000_3000, '0);
        access(1'b0, 32'h0000_1000, '0);
        access(1'b1, 32'h0000_1008, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_1008, '0);
        access(1'b1, 32'h0000_5000, 32'h1234_5678);
        access(1'b0, 32'h0000_5000, '0);
        access(1'b0, 32'h0000_1040, '0);
        access(1'b0, 32'h0000_1044, '0);

        @(negedge clk);
        bus.i_flush = 1'b1; bus.i_req = 1'b1; bus.i_wen = 1'b0; bus.i_addr = 32'h0000_1044;
        #1;
        chk("flush_ready", {31'b0, bus.o_ready}, 32'd0);
        @(negedge clk);
        bus.i_flush = 1'b0; bus.i_req = 1'b0;
        @(negedge clk); #1;
        chk("flush_noreq", {31'b0, bus.o_mreq}, 32'd0);
        clear_model();
        access(1'b0, 32'h0000_1044, '0);
        access(1'b0, 32'h0000_5000, '0);

        ackq.delete();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wen = 1'b0; bus.i_addr = 32'h0000_2004;
        n = 0;
        while (ackq.size() < 2 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("rf_beat2_seen", ackq.size(), 32'd2);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_mreq", {31'b0, bus.o_mreq}, 32'd0);
        chk("abort_maddr", bus.o_maddr, 32'd0);
        chk("abort_ready", {31'b0, bus.o_ready}, 32'd0);
        rst = 1'b0; bus.i_req = 1'b0;
        clear_model();
        access(1'b0, 32'h0000_2004, '0);

        stall = 5;
        access(1'b0, 32'h0000_7008, '0);
        access(1'b0, 32'h0000_700C, '0);
        access(1'b1, 32'h0000_7000, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_7000, '0);
        stall = 0;

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 2) == 0), {18'h0, 12'($urandom_range(0, 4095)), 2'b00}, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cache_dm.md
Name: cache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate cache with multi-word lines.
- Generalised successor of the single-word I/D caches.
- Owns its refill/write-through state machine and a req/ack memory-side handshake, so the core no longer drives fills itself.
- Sits between the core's load/store (or fetch) port and the memory/bus arbiter; usable as I-cache by tying i_wen low.

Parameters:
- LINES, 32, number of lines; power of two, at least 2. IDX = log2(LINES).
- WORDS, 4, 32-bit words per line; power of two, at least 1. OFF = log2(WORDS), 0 allowed.
- TAGW, 30-IDX-OFF, tag width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  core request valid; held with i_wen/i_addr/i_wdata stable until o_ready
- i_wen  in  1  1 = store, 0 = load
- i_addr  in  32  byte address; bits [1:0] ignored
- i_wdata  in  32  store data
- i_flush  in  1  invalidate all lines
- o_ready  out  1  request complete this cycle
- o_rdata  out  32  load data, valid when o_ready && !i_wen
- o_hit  out  1  combinational lookup hit for i_addr
- o_mreq  out  1  memory request valid
- o_mwen  out  1  memory write
- o_maddr  out  32  memory word address, bits [1:0] = 0
- o_mwdata  out  32  memory write data
- i_mack  in  1  memory accepts/completes the beat; i_mrdata valid for reads
- i_mrdata  in  32  memory read data

Behaviour:
- Address split: offset = i_addr[OFF+1:2], index = i_addr[IDX+OFF+1:OFF+2], tag = i_addr[31:IDX+OFF+2].
- Storage: per line, one valid bit, TAGW tag bits and WORDS x 32 data bits.
- o_hit = valid[index] && tag match. o_rdata = data[index][offset], combinational.
- Reset / flush:
  - On rst, all valid bits = 0, state = IDLE, counter = 0.
  - Outputs after reset: o_ready = 0, o_mreq = 0, o_mwen = 0, o_maddr = 0, o_mwdata = 0.
  - Data array is not reset.
  - rst during REFILL or WRITE aborts the operation; o_mreq is 0 from the next cycle; a partly filled line stays invalid.
- States: IDLE, REFILL, WRITE.
- IDLE:
  - i_flush: clear all valid bits this cycle; no request is accepted this cycle; o_ready = 0.
  - Load hit: o_ready = 1 in the same cycle (0-cycle latency); stay in IDLE.
  - Load miss: go to REFILL; cnt = 0; latch the line base address.
  - Store: go to WRITE; latch address and data.
- REFILL:
  - o_mreq = 1, o_mwen = 0, o_maddr = {tag, index, cnt, 2'b00}.
  - Each i_mack cycle writes i_mrdata to data[index][cnt] and increments cnt.
  - On the ack with cnt == WORDS-1: write the tag, set valid, return to IDLE.
  - The held request then hits on the following cycle. Miss latency = WORDS acks + 1 cycle.
  - o_ready = 0 throughout. i_flush is ignored.
- WRITE:
  - o_mreq = 1, o_mwen = 1, o_maddr = latched word address, o_mwdata = latched data.
  - On i_mack: if the line hits, update data[index][offset]; a miss does not allocate. Assert o_ready = 1 that cycle and return to IDLE.
  - i_flush is ignored.
- o_mreq and o_maddr stay stable until i_mack. o_mreq may be asserted on the cycle after entering REFILL or WRITE and remains high across back-to-back refill beats.
- Wrap: cnt is OFF bits wide and wraps to 0 after the last beat. With WORDS = 1, refill is a single beat.
- i_req dropped mid-operation: the in-flight memory transaction still completes; o_ready is not asserted.

Test Plan:
- Reset with LINES=32, WORDS=4, then a load to 0x0000_1004 → o_hit = 0. Refill presents o_maddr 0x1000, 0x1004, 0x1008, 0x100C, one ack each. o_ready rises the cycle after the 4th ack with o_rdata = mem[0x1004]. A following load to 0x100C hits with 0 latency.
- Conflict: fill 0x1000, then load 0x3000 (same index, different tag) → miss and refill. A reload of 0x1000 misses again.
- Store 0xDEADBEEF to 0x1008 while the line is resident → one write beat with o_mwen = 1. o_ready is asserted on the ack. A subsequent load returns 0xDEADBEEF as a hit.
- Store to a non-resident 0x5000 → memory write only. A subsequent load of 0x5000 misses (no allocate).
- i_flush in IDLE after fills → every later load misses. Asserting rst during the 2nd refill beat → o_mreq drops the next cycle, and a reload of the same address misses.
- Ack stall: hold i_mack low for 5 cycles per beat → o_maddr stays constant, no data is written, and the final result matches the no-stall case.
